// File: rtl/iter_cmp_seq.sv
// Sequential unsigned comparator: scans A/B MSB-first, BPC bits per clock, and reports
// the relation selected by {z,y} on f. Optional macro ITER_CMP_EARLY_EXIT_EN ends the scan at the first differing group.
module iter_cmp_seq #(
    parameter int WIDTH = 16,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             z,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             f
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int NG = 2 ** CW;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       mode_reg;
    logic [CW-1:0]    cnt_reg;
    logic             eq_reg;
    logic             gt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             f_reg;

    // Group table padded to a power of two so cnt_reg indexes it without width games.
    logic [BPC-1:0] a_grp [NG];
    logic [BPC-1:0] b_grp [NG];

    generate
        for (genvar gi = 0; gi < NG; gi++) begin : g_grp
            if (gi < N) begin : g_real
                assign a_grp[gi] = a_reg[WIDTH-1-gi*BPC -: BPC];
                assign b_grp[gi] = b_reg[WIDTH-1-gi*BPC -: BPC];
            end else begin : g_pad
                assign a_grp[gi] = '0;
                assign b_grp[gi] = '0;
            end
        end
    endgenerate

    logic [BPC-1:0] a_cur;
    logic [BPC-1:0] b_cur;
    logic           differ;
    logic           eq_next;
    logic           gt_next;
    logic           last_grp;
    logic           result;

    assign a_cur = a_grp[cnt_reg];
    assign b_cur = b_grp[cnt_reg];

    always_comb begin
        differ  = (a_cur != b_cur);
        eq_next = eq_reg;
        gt_next = gt_reg;
        // Only the most significant differing group decides the ordering.
        if (eq_reg && differ) begin
            eq_next = 1'b0;
            gt_next = (a_cur > b_cur);
        end
`ifdef ITER_CMP_EARLY_EXIT_EN
        last_grp = (cnt_reg == CW'(N - 1)) || (eq_reg && differ);
`else
        last_grp = (cnt_reg == CW'(N - 1));
`endif
        case (mode_reg)
            2'b00:   result = eq_next;
            2'b01:   result = gt_next;
            2'b10:   result = !eq_next && !gt_next;
            default: result = !eq_next;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            f_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        mode_reg  <= {z, y};
                        eq_reg    <= 1'b1;
                        gt_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SCAN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SCAN: begin
                    eq_reg  <= eq_next;
                    gt_reg  <= gt_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_grp) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        f_reg     <= result;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign f    = f_reg;
endmodule

// File: tb/tb_iter_cmp_seq.sv
// Self-checking bench for iter_cmp_seq: a 16x1 and a 32x4 instance checked against an
// arithmetic reference model (relation from plain compares, latency from a group scan).
module tb_iter_cmp_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start32;
    logic [15:0] a16, b16;
    logic [31:0] a32, b32;
    logic        z, y;
    logic        busy16, done16, f16;
    logic        busy32, done32, f32;

    int checks = 0;
    int errors = 0;
    bit sel = 1'b0;
    bit exp_f [2];

    always #5 clk = ~clk;

    iter_cmp_seq #(.WIDTH(16), .BPC(1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .z(z), .y(y),
        .busy(busy16), .done(done16), .f(f16)
    );

    iter_cmp_seq #(.WIDTH(32), .BPC(4)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .z(z), .y(y),
        .busy(busy32), .done(done32), .f(f32)
    );

    logic cur_busy, cur_done, cur_f;
    assign cur_busy = sel ? busy32 : busy16;
    assign cur_done = sel ? done32 : done16;
    assign cur_f    = sel ? f32    : f16;

    function automatic bit ref_f(input logic [31:0] a, b, input logic [1:0] m, input bit s);
        logic [31:0] am, bm;
        am = s ? a : {16'h0, a[15:0]};
        bm = s ? b : {16'h0, b[15:0]};
        case (m)
            2'b00:   return am == bm;
            2'b01:   return am > bm;
            2'b10:   return am < bm;
            default: return am != bm;
        endcase
    endfunction

    function automatic int ref_lat(input logic [31:0] a, b, input bit s);
        int w, bpc, n;
        w   = s ? 32 : 16;
        bpc = s ? 4 : 1;
        n   = w / bpc;
`ifdef ITER_CMP_EARLY_EXIT_EN
        for (int g = 0; g < n; g++) begin
            int sh;
            logic [31:0] mask;
            sh   = w - (g + 1) * bpc;
            mask = (32'h1 << bpc) - 32'h1;
            if (((a >> sh) & mask) != ((b >> sh) & mask)) return g + 1;
        end
`endif
        return n;
    endfunction

    task automatic drive(input logic [31:0] a, b, input logic [1:0] m, input bit st);
        {z, y} = m;
        if (sel) begin
            a32 = a; b32 = b; start32 = st;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; start16 = st;
        end
    endtask

    task automatic set_start(input bit st);
        if (sel) start32 = st;
        else start16 = st;
    endtask

    // Starts a comparison at the next edge and follows it to done; optionally disturbs
    // inputs during the scan, or holds start with new operands through DONE.
    task automatic run_cmp(input bit s, input logic [31:0] a, b, input logic [1:0] m,
                           input bit scramble, input bit chain,
                           input logic [31:0] na, nb, input logic [1:0] nm, input string name);
        int lat, cyc;
        bit seen, fe;
        sel = s;
        lat = ref_lat(a, b, s);
        fe  = ref_f(a, b, m, s);
        drive(a, b, m, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (cur_done) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (cur_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_scan cyc=%0d got=%b exp=1", name, cyc, cur_busy);
                end
                checks++;
                if (cur_f !== exp_f[s]) begin
                    errors++;
                    $display("FAIL %s f_held cyc=%0d got=%b exp=%b", name, cyc, cur_f, exp_f[s]);
                end
                if (scramble && cyc < lat - 1)
                    drive($urandom, $urandom, 2'($urandom), 1'($urandom));
                else if (scramble)
                    set_start(1'b0);
                if (chain && cyc == lat - 1)
                    drive(na, nb, nm, 1'b1);
                cyc++;
                @(negedge clk);
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout got=no_done exp=done_after_%0d", name, lat);
        end else begin
            checks++;
            if (cyc != lat) begin
                errors++;
                $display("FAIL %s latency got=%0d exp=%0d", name, cyc, lat);
            end
            checks++;
            if (cur_f !== fe) begin
                errors++;
                $display("FAIL %s result got=%b exp=%b", name, cur_f, fe);
            end
            checks++;
            if (cur_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_done got=%b exp=0", name, cur_busy);
            end
        end
        $display("%s: w=%0d A=%h B=%h zy=%b lat=%0d f=%b", name, s ? 32 : 16, a, b, m, cyc, cur_f);
        exp_f[s] = fe;
        if (!chain) begin
            @(negedge clk);
            checks++;
            if (cur_done !== 1'b0 || cur_busy !== 1'b0 || cur_f !== fe) begin
                errors++;
                $display("FAIL %s after_done got=done%b busy%b f%b exp=done0 busy0 f%b",
                         name, cur_done, cur_busy, cur_f, fe);
            end
        end
    endtask

    task automatic test_reset;
        int dones;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_f[0] = 1'b0;
        exp_f[1] = 1'b0;
        repeat (2) begin
            checks++;
            if ({busy16, done16, f16, busy32, done32, f32} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle got=%b exp=000000",
                         {busy16, done16, f16, busy32, done32, f32});
            end
            @(negedge clk);
        end
        sel = 1'b0;
        drive(32'h00000001, 32'h00000000, 2'b01, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (busy16 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy got=%b exp=1", busy16);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy16, done16, f16} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_scan got=%b exp=000", {busy16, done16, f16});
        end
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done16 || f16) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_no_done got=%0d exp=0", dones);
        end
        $display("reset: mid-scan abort checked");
    endtask

    task automatic test_modes;
        run_cmp(0, 32'h1234, 32'h1234, 2'b00, 0, 0, 0, 0, 0, "eq_same");
        run_cmp(0, 32'h1234, 32'h1234, 2'b11, 0, 0, 0, 0, 0, "ne_same");
        run_cmp(0, 32'h8000, 32'h7FFF, 2'b01, 0, 0, 0, 0, 0, "gt_msb");
        run_cmp(0, 32'h8000, 32'h7FFF, 2'b10, 0, 0, 0, 0, 0, "lt_msb");
        run_cmp(0, 32'h00FE, 32'h00FF, 2'b10, 0, 0, 0, 0, 0, "lt_lsb");
        run_cmp(0, 32'hFFFF, 32'h0000, 2'b00, 0, 0, 0, 0, 0, "eq_extreme");
    endtask

    task automatic test_ignore_inputs;
        run_cmp(0, 32'h00FE, 32'h00FF, 2'b10, 1, 0, 0, 0, 0, "scramble_lt");
        run_cmp(0, 32'hABCD, 32'hABCD, 2'b00, 1, 0, 0, 0, 0, "scramble_eq");
    endtask

    task automatic test_back_to_back;
        run_cmp(0, 32'h8000, 32'h7FFF, 2'b01, 0, 1, 32'h3, 32'h5, 2'b01, "b2b_first");
        run_cmp(0, 32'h3, 32'h5, 2'b01, 0, 0, 0, 0, 0, "b2b_second");
    endtask

    task automatic test_param;
        run_cmp(1, 32'hFFFF0000, 32'hFFFE0000, 2'b01, 0, 0, 0, 0, 0, "w32_gt");
        run_cmp(1, 32'h0000000F, 32'h0000000E, 2'b10, 0, 0, 0, 0, 0, "w32_lt_lsb");
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : a ^ (32'h1 << $urandom_range(0, 31));
            run_cmp(1'(i % 2), a, b, 2'($urandom), 1'($urandom), 0, 0, 0, 0, "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        start16 = 1'b0; start32 = 1'b0;
        a16 = '0; b16 = '0; a32 = '0; b32 = '0;
        z = 1'b0; y = 1'b0;
        @(negedge clk);
        test_reset;
        test_modes;
        test_ignore_inputs;
        test_back_to_back;
        test_param;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
